// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and constants for the MIPS core
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with load/bubble/hold controls
// load has priority over bubble; neither asserted means hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [WORD_W-1:0] pc_d,
  input  logic [WORD_W-1:0] instr_d,
  input  logic              valid_d,
  output logic [WORD_W-1:0] pc_q,
  output logic [WORD_W-1:0] instr_q,
  output logic              valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end else if (bubble) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch-stage controller: PC, imem handshake, IF/ID load
// FETCH_PERF_CNT_EN enables the bubble/flush performance counters.
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] newPC,
  input  logic              Flush,
  input  logic              Stall,
  output logic [WORD_W-1:0] oldPC,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] PC_ID,
  output logic [WORD_W-1:0] Instr_ID,
  output logic              Valid_ID,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
);

  fetch_state_t      state;
  logic [WORD_W-1:0] redirect;
  logic [WORD_W-1:0] skid;

  logic              id_load;
  logic              id_bubble;
  logic [WORD_W-1:0] id_instr;
  logic              id_valid;
  logic              flush_ok;

  assign flush_ok  = !Stall && Flush;
  assign imem_req  = (state != HOLD);
  assign imem_addr = oldPC;

  always_comb begin
    id_load   = 1'b0;
    id_bubble = 1'b0;
    id_instr  = NOP_INSTR;
    id_valid  = 1'b0;
    if (!Stall) begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            id_load  = 1'b1;
            id_instr = Flush ? NOP_INSTR : imem_rdata;
            id_valid = !Flush;
          end else begin
            id_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (Flush) begin
            id_bubble = 1'b1;
          end else begin
            id_load  = 1'b1;
            id_instr = skid;
            id_valid = 1'b1;
          end
        end
        KILL:    id_bubble = 1'b1;
        default: id_bubble = 1'b1;
      endcase
    end
  end

  // The KILL drain completes on imem_ready even under Stall: the stale
  // response is dropped and the request must not be reissued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      oldPC    <= RESET_PC;
      redirect <= '0;
      skid     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!Stall) begin
            if (imem_ready) begin
              oldPC <= newPC;
            end else if (Flush) begin
              redirect <= newPC;
              state    <= KILL;
            end
          end else if (imem_ready) begin
            skid  <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!Stall) begin
            oldPC <= newPC;
            state <= FETCH;
          end
        end
        KILL: begin
          if (flush_ok) redirect <= newPC;
          if (imem_ready) begin
            oldPC <= flush_ok ? newPC : redirect;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (id_load),
    .bubble  (id_bubble),
    .pc_d    (oldPC),
    .instr_d (id_instr),
    .valid_d (id_valid),
    .pc_q    (PC_ID),
    .instr_q (Instr_ID),
    .valid_q (Valid_ID)
  );

`ifdef FETCH_PERF_CNT_EN
  logic starved;
  assign starved = !Stall && ((state == FETCH && !imem_ready) || state == KILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (starved)  bubble_cnt <= bubble_cnt + 32'd1;
      if (flush_ok) flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage controller for the 5-stage pipelined MIPS core. It sits on the other end of the next-PC interface.
- Owns the PC register and drives oldPC to the next-PC unit. Consumes newPC/Flush from that unit and the hazard Stall.
- Talks to a variable-latency instruction memory with a req/ready handshake and loads the IF/ID pipeline register (PC_ID, Instr_ID, Valid_ID).
- Correctly handles redirects that arrive while an imem access is outstanding.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on bubbles/flushes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
newPC  in  32  next PC from next-PC unit
Flush  in  1  redirect taken in ID; kill instruction in IF
Stall  in  1  hazard stall (OR of load-use and branch-operand stalls); IF/ID and PC hold
oldPC  out  32  current fetch PC (PC register)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= oldPC)
imem_ready  in  1  imem_rdata valid this cycle; completes the request
imem_rdata  in  32  fetched instruction
PC_ID  out  32  IF/ID PC
Instr_ID  out  32  IF/ID instruction
Valid_ID  out  1  IF/ID holds a real instruction
bubble_cnt  out  32  perf counter (see Optional Feature)
flush_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at posedge): oldPC=RESET_PC, state=FETCH, PC_ID=0, Instr_ID=NOP_INSTR, Valid_ID=0, redirect reg=0, skid buffer=0, counters=0. rst overrides all other inputs. A request in flight at reset is abandoned; a late imem_ready after reset is accepted as the response to the new RESET_PC fetch (the imem is reset together with the core).
- States:
  - FETCH: imem_req=1.
  - HOLD: instruction buffered in skid; imem_req=0.
  - KILL: stale request draining; imem_req=1, imem_addr=oldPC (stale address held stable).
- imem_addr=oldPC always. The request stays asserted and stable until imem_ready. Minimum latency is 0 wait cycles (ready in the same cycle as req).
- Priority every cycle: rst > Stall > Flush > normal. Stall with Flush set means Flush is ignored, matching the next-PC unit forcing Flush=0 under stall.
- FETCH transitions:
  - ready & !Stall & !Flush: IF/ID <= {oldPC, imem_rdata, 1}; oldPC <= newPC; stay FETCH.
  - ready & !Stall & Flush: IF/ID <= {oldPC, NOP_INSTR, 0}; oldPC <= newPC; stay FETCH.
  - ready & Stall: IF/ID holds; skid <= imem_rdata; oldPC holds; go HOLD.
  - !ready & !Stall & !Flush: IF/ID <= bubble (Valid_ID=0, Instr_ID=NOP_INSTR); oldPC holds; stay FETCH.
  - !ready & !Stall & Flush: IF/ID <= bubble; redirect <= newPC; go KILL.
  - !ready & Stall: everything holds.
- HOLD transitions:
  - Stall: hold.
  - !Stall & !Flush: IF/ID <= {oldPC, skid, 1}; oldPC <= newPC; go FETCH.
  - !Stall & Flush: IF/ID <= bubble; oldPC <= newPC; skid discarded; go FETCH.
- KILL transitions:
  - ready: response discarded; oldPC <= redirect; go FETCH.
  - !ready: wait.
  - While in KILL with !Stall, IF/ID loads a bubble.
  - A further Flush while in KILL (with !Stall) overwrites redirect with newPC.
- No instruction is ever delivered twice. No response is ever delivered for a killed address.
- Back-to-back 0-wait fetches give one instruction per cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on every cycle IF/ID loads a bubble because no instruction was available (FETCH/KILL, !Stall).
  - flush_cnt increments on every accepted Flush (!Stall & Flush).
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports tied to 0 and no counter flops.

Decomposition:
- Shared package cpu_pkg:
  - Fetch state enum (FETCH, HOLD, KILL).
  - NOP_INSTR and RESET_PC default constants.
  - 32-bit word width constant.
- One sub-module, if_id_reg: the IF/ID register with load/bubble/hold controls. It is reused by the other pipeline registers.

Test Plan:
- Reset then 0-wait imem with sequential newPC=oldPC+4 -> oldPC 3000,3004,3008; one cycle after each, PC_ID lags by one with Valid_ID=1 every cycle; instructions in order.
- imem_ready delayed 3 cycles at 3004 -> oldPC held at 3004 for 3 cycles; 3 bubbles (Valid_ID=0, Instr_ID=0); bubble_cnt=3 with macro.
- ready at 3008 with Stall=1 for 2 cycles -> HOLD, imem_req=0, IF/ID unchanged; on Stall release, PC_ID=3008 with the buffered word; oldPC=newPC.
- Flush=1, newPC=3100 while a fetch of 300C is pending for 2 more cycles -> KILL; 300C response never appears in IF/ID; next request address 3100; flush_cnt=1.
- Flush=1 and Stall=1 in the same cycle -> Flush ignored; PC and IF/ID hold.
- rst asserted mid-KILL -> next cycle oldPC=3000, Valid_ID=0, state FETCH, counters 0.
